// File: rtl/serial_addsub_unit.sv
// rtl/serial_addsub_unit.sv - digit-serial two's-complement adder/subtractor with handshake and flags
module serial_addsub_unit #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = $clog2(NDIG) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [DIGIT:0]   sum;
  logic             msb_cin;
  logic [WIDTH-1:0] digit_ext;
  logic [WIDTH-1:0] res_next;

  // Carry into the digit's top bit is recovered from the sum bit, so DIGIT = 1 needs no special case.
  always_comb begin
    sum       = {1'b0, a_sr[DIGIT-1:0]} + {1'b0, b_sr[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    msb_cin   = sum[DIGIT-1] ^ a_sr[DIGIT-1] ^ b_sr[DIGIT-1];
    digit_ext = WIDTH'(sum[DIGIT-1:0]);
    res_next  = (result >> DIGIT) | (digit_ext << (WIDTH - DIGIT));
  end

  assign in_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      cnt       <= '0;
      a_sr      <= '0;
      b_sr      <= '0;
      carry     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sr  <= a;
            b_sr  <= b ^ {WIDTH{sel}};
            carry <= sel ? ~cin : cin;
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          a_sr   <= a_sr >> DIGIT;
          b_sr   <= b_sr >> DIGIT;
          carry  <= sum[DIGIT];
          result <= res_next;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(NDIG - 1)) begin
            cout      <= sum[DIGIT];
            ovf       <= msb_cin ^ sum[DIGIT];
            zero      <= (res_next == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_addsub_unit.sv
// tb/tb_serial_addsub_unit.sv - self-checking bench for serial_addsub_unit (DIGIT = 4, 16 and 1 side by side)
module tb_serial_addsub_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, in_valid, out_ready, sel, cin;
  logic [15:0]     a, b;
  logic [2:0]      in_ready, out_valid, cout, ovf, zero;
  logic [2:0][15:0] res;

  int total = 0;
  int bad   = 0;

  serial_addsub_unit #(.WIDTH(16), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]), .a(a), .b(b),
    .sel(sel), .cin(cin), .out_valid(out_valid[0]), .out_ready(out_ready),
    .result(res[0]), .cout(cout[0]), .ovf(ovf[0]), .zero(zero[0]));

  serial_addsub_unit #(.WIDTH(16), .DIGIT(16)) u_d16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]), .a(a), .b(b),
    .sel(sel), .cin(cin), .out_valid(out_valid[1]), .out_ready(out_ready),
    .result(res[1]), .cout(cout[1]), .ovf(ovf[1]), .zero(zero[1]));

  serial_addsub_unit #(.WIDTH(16), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]), .a(a), .b(b),
    .sel(sel), .cin(cin), .out_valid(out_valid[2]), .out_ready(out_ready),
    .result(res[2]), .cout(cout[2]), .ovf(ovf[2]), .zero(zero[2]));

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic        s;
    logic        c;
    logic [15:0] r;
    logic        co;
    logic        ov;
    logic        z;
  } vec_t;

  function automatic int ndig(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 1 : 16);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands' unsigned and signed values.
  function automatic void model(input logic [15:0] x, input logic [15:0] y, input logic s, input logic c,
                                output logic [15:0] r, output logic co, output logic ov, output logic z);
    int ux, uy, sx, sy, uv, sv, ci;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    ci = c ? 1 : 0;
    if (s) begin
      uv = ux - uy - ci;
      sv = sx - sy - ci;
      co = (uv >= 0);
    end else begin
      uv = ux + uy + ci;
      sv = sx + sy + ci;
      co = (uv > 65535);
    end
    r  = uv[15:0];
    ov = (sv > 32767) || (sv < -32768);
    z  = (r == 16'h0000);
  endfunction

  task automatic start_op(input logic [15:0] x, input logic [15:0] y, input logic s, input logic c);
    int t;
    t = 0;
    while (in_ready !== 3'b111 && t < 60) begin
      @(negedge clk);
      t++;
    end
    check("start_ready", in_ready, 3'b111);
    a = x; b = y; sel = s; cin = c; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called at the falling edge right after the accept edge.
  task automatic finish_op(input string name, input logic [15:0] r, input logic co, input logic ov, input logic z);
    int lat[3];
    for (int i = 0; i < 3; i++) lat[i] = 0;
    check($sformatf("%s_early_valid", name), out_valid, 3'b000);
    for (int t = 1; t <= 40; t++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) if (out_valid[i] && lat[i] == 0) lat[i] = t;
      if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_lat_d%0d", name, ndig(i)), lat[i], ndig(i));
      check($sformatf("%s_res_d%0d", name, ndig(i)), res[i], r);
      check($sformatf("%s_cout_d%0d", name, ndig(i)), cout[i], co);
      check($sformatf("%s_ovf_d%0d", name, ndig(i)), ovf[i], ov);
      check($sformatf("%s_zero_d%0d", name, ndig(i)), zero[i], z);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check($sformatf("%s_valid_drop", name), out_valid, 3'b000);
    check($sformatf("%s_idle_ready", name), in_ready, 3'b111);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[7];
    logic [15:0] x, y, r;
    logic        s, c, co, ov, z;
    int          t;
    logic        seen;

    vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{16'h0007, 16'h0005, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{16'h0005, 16'h0005, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; out_ready = 1'b0; sel = 1'b0; cin = 1'b0;
    a = 16'h0001; b = 16'h0001; in_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 3'b000);
    check("rst_out_valid", out_valid, 3'b000);
    check("rst_cout", cout, 3'b000);
    check("rst_ovf", ovf, 3'b000);
    check("rst_zero", zero, 3'b000);
    for (int i = 0; i < 3; i++) check($sformatf("rst_result_d%0d", ndig(i)), res[i], 16'h0000);
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_ready", in_ready, 3'b111);
    check("post_rst_no_valid", out_valid, 3'b000);

    for (int v = 0; v < 7; v++) begin
      start_op(vecs[v].x, vecs[v].y, vecs[v].s, vecs[v].c);
      finish_op($sformatf("vec%0d", v), vecs[v].r, vecs[v].co, vecs[v].ov, vecs[v].z);
    end

    for (int n = 0; n < 30; n++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      if (n % 5 == 0) x = 16'h8000;
      if (n % 7 == 0) y = 16'hFFFF;
      s = 1'($urandom_range(0, 1));
      c = 1'($urandom_range(0, 1));
      model(x, y, s, c, r, co, ov, z);
      start_op(x, y, s, c);
      finish_op($sformatf("rnd%0d", n), r, co, ov, z);
    end

    // Backpressure: results frozen in DONE while new operands are offered.
    start_op(16'h1111, 16'h2222, 1'b0, 1'b0);
    t = 0;
    while (!out_valid[0] && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("bp_first_valid", out_valid[0], 1'b1);
    a = 16'hABCD; b = 16'h1234; sel = 1'b1; cin = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("bp_hold_res%0d", k), res[0], 16'h3333);
      check($sformatf("bp_hold_valid%0d", k), out_valid[0], 1'b1);
      check($sformatf("bp_hold_ready%0d", k), in_ready[0], 1'b0);
      check($sformatf("bp_hold_flags%0d", k), {cout[0], ovf[0], zero[0]}, 3'b000);
    end
    t = 0;
    while (out_valid !== 3'b111 && t < 30) begin
      @(negedge clk);
      t++;
    end
    check("bp_all_valid", out_valid, 3'b111);
    for (int i = 0; i < 3; i++) check($sformatf("bp_res_d%0d", ndig(i)), res[i], 16'h3333);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_idle_cycle_ready", in_ready, 3'b111);
    check("bp_idle_cycle_valid", out_valid, 3'b000);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_second_accepted", in_ready, 3'b000);
    model(16'hABCD, 16'h1234, 1'b1, 1'b0, r, co, ov, z);
    finish_op("bp_second", r, co, ov, z);

    // Reset after two digits of the DIGIT=4 instance.
    start_op(16'h4321, 16'h1111, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ready_low", in_ready, 3'b000);
    rst = 1'b0;
    #1;
    check("midrst_ready_after", in_ready, 3'b111);
    seen = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (out_valid !== 3'b000) seen = 1'b1;
    end
    check("midrst_no_valid", seen, 1'b0);
    start_op(16'h0001, 16'h0001, 1'b0, 1'b0);
    finish_op("after_rst", 16'h0002, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
